// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared widths and timing constants for the pixel counters.
//  Revision    : 1.0  initial release
// ============================================================================
package video_timing_pkg;

    // Default width of every count and total bus.
    localparam int unsigned CNT_W_DEF = 12;

    // Smallest usable limit; a programmed total of zero behaves as this.
    localparam int unsigned MIN_LIMIT = 1;

    // Example timing used when bringing a board up without a mode table.
    localparam int unsigned H_TOTAL_BRINGUP = 10;
    localparam int unsigned V_TOTAL_BRINGUP = 5;

endpackage : video_timing_pkg
`default_nettype wire

// File: rtl/pixel_counters_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_counters_if
//  Description : Totals in, counts and start strobes out, for the pixel
//                counter block. The master side programs the totals and
//                consumes the counts; the slave side is the counter itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pixel_counters_if
    import video_timing_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             line_start;
    logic             frame_start;

    modport master (
        output h_total,
        output v_total,
        input  h_count,
        input  v_count,
        input  line_start,
        input  frame_start
    );

    modport slave (
        input  h_total,
        input  v_total,
        output h_count,
        output v_count,
        output line_start,
        output frame_start
    );

endinterface : pixel_counters_if
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_counter
//  Description : Enabled up-counter that returns to zero after limit-1.
//                The terminal test is ">=" so a count left above the limit
//                (limit shrunk while the count sat high) still wraps on the
//                next enabled edge instead of running up to the top value.
//                i_limit must be at least 1.
//  Revision    : 1.0  initial release
// ============================================================================
module wrap_counter #(
    parameter int CNT_W = 12
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_en,
    input  wire  [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_last;
    logic             w_at_last;

    // Terminal-count decode; i_limit >= 1 so the subtraction cannot underflow.
    always_comb begin
        w_last    = i_limit - CNT_W'(1);
        w_at_last = (r_count >= w_last);
    end

    // Count register: clear on reset, step or wrap when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_en & w_at_last;

endmodule : wrap_counter
`default_nettype wire

// File: rtl/pixel_counters.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_counters
//  Description : Horizontal/vertical raster counters. Totals are captured in
//                shadow registers during reset and at the end of every frame,
//                so reprogramming mid-frame only takes effect from the next
//                frame. line_start/frame_start decode the count registers and
//                are held low while reset is asserted. The reset input is
//                active-high even though it carries an _n suffix.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_counters
    import video_timing_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire              pixel_clk,
    input  wire              rst_n,
    pixel_counters_if.slave  bus
);

    logic [CNT_W-1:0] r_h_tot_q;
    logic [CNT_W-1:0] r_v_tot_q;
    logic [CNT_W-1:0] w_h_lim;
    logic [CNT_W-1:0] w_v_lim;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_frame_wrap;

    // Shadow totals: follow the inputs during reset, then latch at frame end.
    always_ff @(posedge pixel_clk) begin
        if (rst_n || w_frame_wrap) begin
            r_h_tot_q <= bus.h_total;
            r_v_tot_q <= bus.v_total;
        end
    end

    // Effective limits: a zero total behaves as a one-pixel / one-line raster.
    always_comb begin
        w_h_lim = (r_h_tot_q == '0) ? CNT_W'(MIN_LIMIT) : r_h_tot_q;
        w_v_lim = (r_v_tot_q == '0) ? CNT_W'(MIN_LIMIT) : r_v_tot_q;
    end

    // Pixel counter runs every cycle.
    wrap_counter #(
        .CNT_W   (CNT_W)
    ) u_h_cnt (
        .clk     (pixel_clk),
        .rst     (rst_n),
        .i_en    (1'b1),
        .i_limit (w_h_lim),
        .o_count (w_h_count),
        .o_wrap  (w_h_wrap)
    );

    // Line counter advances once per completed line.
    wrap_counter #(
        .CNT_W   (CNT_W)
    ) u_v_cnt (
        .clk     (pixel_clk),
        .rst     (rst_n),
        .i_en    (w_h_wrap),
        .i_limit (w_v_lim),
        .o_count (w_v_count),
        .o_wrap  (w_v_wrap)
    );

    // Last pixel of the last line: the edge that returns the raster to (0,0).
    assign w_frame_wrap = w_h_wrap & w_v_wrap;

    // Start strobes decoded from the count registers, masked during reset.
    always_comb begin
        bus.line_start  = 1'b0;
        bus.frame_start = 1'b0;
        if (!rst_n) begin
            bus.line_start  = (w_h_count == '0);
            bus.frame_start = (w_h_count == '0) && (w_v_count == '0);
        end
    end

    assign bus.h_count = w_h_count;
    assign bus.v_count = w_v_count;

endmodule : pixel_counters
`default_nettype wire

// File: tb/tb_pixel_counters.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_counters
//  Description : Directed bench for pixel_counters. Cycle 0 is the first
//                cycle after reset is released; expected raster positions are
//                derived from the cycle number and the programmed totals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_counters;

    localparam int CNT_W = 12;

    logic pixel_clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    pixel_counters_if #(.CNT_W(CNT_W)) bus ();

    pixel_counters #(
        .CNT_W     (CNT_W)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d", tag, obs, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // Check full raster state against an expected position.
    task automatic check_pos(input string tst, input int c, input int h_e, input int v_e);
        check($sformatf("%s c%0d h", tst, c), 32'(bus.h_count), h_e);
        check($sformatf("%s c%0d v", tst, c), 32'(bus.v_count), v_e);
        check($sformatf("%s c%0d ls", tst, c), 32'(bus.line_start), (h_e == 0) ? 1 : 0);
        check($sformatf("%s c%0d fs", tst, c), 32'(bus.frame_start), (h_e == 0 && v_e == 0) ? 1 : 0);
    endtask

    // Hold reset five cycles with the given totals, check, then release.
    task automatic do_reset(input string tst, input int h_tot, input int v_tot);
        bus.h_total = CNT_W'(h_tot);
        bus.v_total = CNT_W'(v_tot);
        rst_n = 1'b1;
        repeat (5) step();
        check({tst, " rst h"},  32'(bus.h_count), 0);
        check({tst, " rst v"},  32'(bus.v_count), 0);
        check({tst, " rst ls"}, 32'(bus.line_start), 0);
        check({tst, " rst fs"}, 32'(bus.frame_start), 0);
        rst_n = 1'b0;
        #1;
    endtask

    initial begin
        int fs_hits;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b1;
        bus.h_total = '0;
        bus.v_total = '0;

        // 10x5 raster for 100 cycles: period 50, frame_start at 0 and 50 only.
        do_reset("base", 10, 5);
        fs_hits = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) step();
            check_pos("base", c, c % 10, (c / 10) % 5);
            if (bus.frame_start === 1'b1) fs_hits++;
        end
        check("base fs count", fs_hits, 2);

        // h_total 10 -> 4 at cycle 20; new raster starts at cycle 50.
        do_reset("chg", 10, 5);
        for (int c = 0; c <= 90; c++) begin
            if (c > 0) step();
            if (c < 50) check_pos("chg", c, c % 10, c / 10);
            else        check_pos("chg", c, (c - 50) % 4, ((c - 50) / 4) % 5);
            if (c == 20) bus.h_total = CNT_W'(4);
        end

        // Reset asserted at (6,3) mid-frame.
        do_reset("midrst", 10, 5);
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) step();
            check_pos("midrst", c, c % 10, c / 10);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("midrst hold%0d h", k),  32'(bus.h_count), 0);
            check($sformatf("midrst hold%0d v", k),  32'(bus.v_count), 0);
            check($sformatf("midrst hold%0d fs", k), 32'(bus.frame_start), 0);
            check($sformatf("midrst hold%0d ls", k), 32'(bus.line_start), 0);
        end
        rst_n = 1'b0;
        #1;
        check_pos("midrst rel", 0, 0, 0);
        step();
        check_pos("midrst rel", 1, 1, 0);

        // Zero h_total acts as one: raster pinned at (0,0), frame_start stuck high.
        do_reset("zero", 0, 1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            check_pos("zero", c, 0, 0);
        end

        // Maximum total: h reaches 4094 then wraps, v toggles.
        do_reset("max", 4095, 2);
        for (int c = 0; c <= 8200; c++) begin
            if (c > 0) step();
            check_pos("max", c, c % 4095, (c / 4095) % 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pixel_counters
`default_nettype wire

// File: doc/pixel_counters.md
PIXEL_COUNTERS -- requirements
Module: pixel_counters

Interface
REQ-001 Parameter CNT_W, default 12, SHALL set the width of all count and total ports.
REQ-002 pixel_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-high (asserted when 1), despite the _n suffix.
REQ-004 h_total  input  CNT_W  SHALL give the total pixels per line, including blanking.
REQ-005 v_total  input  CNT_W  SHALL give the total lines per frame, including blanking.
REQ-006 h_count  output  CNT_W  SHALL give the current pixel index within the line, registered.
REQ-007 v_count  output  CNT_W  SHALL give the current line index within the frame, registered.
REQ-008 line_start  output  1  SHALL be high while h_count==0.
REQ-009 frame_start  output  1  SHALL be high while h_count==0 and v_count==0.

Function
REQ-010 Shadow registers h_tot_q and v_tot_q SHALL hold the active totals; the counters SHALL use only the shadows.
REQ-011 Shadows SHALL load h_total/v_total while reset is asserted, and on the clock edge where the counters wrap from the last pixel of the frame to (0,0).
REQ-012 A total of 0 SHALL be treated as 1 (effective limit = max(total,1)).
REQ-013 Each non-reset edge: if h_count == h_lim-1, h_count SHALL go to 0, else h_count+1.
REQ-014 v_count SHALL change only on an h wrap: 0 if v_count == v_lim-1, else v_count+1.
REQ-015 With h_total=10, v_total=5 the period SHALL be 50 pixel_clk cycles; h runs 0..9; v runs 0..4.
REQ-016 If a shadow changes so that a count already exceeds limit-1 (reset-load case only), the comparison SHALL use >= so the counter wraps on the next edge.
REQ-017 line_start and frame_start SHALL be combinational decodes of the count registers, forced 0 while reset is asserted.
REQ-018 frame_start SHALL be high for exactly one cycle per frame when h_lim*v_lim > 1; it SHALL be high continuously when both limits are 1.
REQ-019 Counter arithmetic SHALL be unsigned CNT_W-bit; the maximum total of 2^CNT_W-1 SHALL be supported without overflow.
REQ-020 Totals changed mid-frame SHALL NOT affect the current frame.

Reset
REQ-021 With rst_n=1 at an edge: h_count=0, v_count=0, shadows loaded, line_start=0, frame_start=0.
REQ-022 On the first cycle after release: h_count=0, v_count=0, frame_start=1, line_start=1.
REQ-023 Reset asserted mid-frame SHALL return to REQ-021 state on the next edge, regardless of count values.

Structure
REQ-024 CNT_W default and any video timing constants SHALL live in a shared package video_timing_pkg.
REQ-025 One sub-module, wrap_counter (count, limit, enable, wrap flag), SHALL be instantiated twice: h (enable=1) and v (enable=h wrap).

Verification
REQ-026 Reset 5 cycles; h_total=10, v_total=5 -> first post-reset cycle (0,0), frame_start=1; next cycle (1,0), frame_start=0.
REQ-027 Run 100 cycles -> frame_start high at cycles 0 and 50 only; (9,0) followed by (0,1); (9,4) followed by (0,0).
REQ-028 Change h_total from 10 to 4 at cycle 20 -> h still wraps at 9 until cycle 50; then period is 4*5=20 cycles.
REQ-029 Assert reset at (6,3) -> next edge gives (0,0) with frame_start=0 while held; release gives (0,0) with frame_start=1.
REQ-030 h_total=0, v_total=1 -> counts stay (0,0); frame_start is constantly 1 after reset.
REQ-031 h_total=4095, v_total=2 -> h reaches 4094 then wraps; v toggles 0/1; no X or overflow.
